// File: rtl/qbank_pkg.sv
// Shared types and constants for the question bank: table entry layout,
// prime-factor codes, FSM state encoding, LFSR constants and the default table.
package qbank_pkg;

    // Field widths of the stored default table
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_LEVEL_W = 2;
    localparam int DEF_DIGITS  = 3;
    localparam int DEF_FACTORS = 3;

    // Galois LFSR, right-shifting form of x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Prime-factor codes; 0 pads unused answer nibbles
    localparam logic [3:0] P_NONE = 4'd0;
    localparam logic [3:0] P_2    = 4'd1;
    localparam logic [3:0] P_3    = 4'd2;
    localparam logic [3:0] P_5    = 4'd3;
    localparam logic [3:0] P_7    = 4'd4;
    localparam logic [3:0] P_11   = 4'd5;
    localparam logic [3:0] P_13   = 4'd6;
    localparam logic [3:0] P_17   = 4'd7;
    localparam logic [3:0] P_19   = 4'd8;
    localparam logic [3:0] P_23   = 4'd9;

    typedef struct packed {
        logic [DEF_LEVEL_W-1:0]   level;
        logic [4*DEF_DIGITS-1:0]  problem;
        logic [4*DEF_FACTORS-1:0] answer;
    } qentry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // 30 = 2*3*5, 27 = 3*3*3, 42 = 2*3*7
    localparam qentry_t ENT_A = '{level: 2'd0, problem: 12'h030, answer: {P_2, P_3, P_5}};
    localparam qentry_t ENT_B = '{level: 2'd0, problem: 12'h027, answer: {P_3, P_3, P_3}};
    localparam qentry_t ENT_C = '{level: 2'd1, problem: 12'h042, answer: {P_2, P_3, P_7}};

    localparam qentry_t DEFAULT_TABLE [DEF_DEPTH] = '{
        ENT_A, ENT_B, ENT_C, ENT_A, ENT_B, ENT_C, ENT_A, ENT_B,
        ENT_C, ENT_A, ENT_B, ENT_C, ENT_A, ENT_B, ENT_C, ENT_A
    };

endpackage

// File: rtl/qbank_lfsr.sv
// Free-running 8-bit Galois LFSR; exposes its low OUT_W bits as a start pointer.
module qbank_lfsr
    import qbank_pkg::*;
#(
    parameter int OUT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [OUT_W-1:0] ptr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next state: shift right, fold the taps in when a one drops out
    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end

    // State register; advances on every non-reset cycle
    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values.
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign ptr_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/q_bank.sv
// Question bank: on a request, scans a constant table from a pseudo-random
// start pointer, one entry per cycle, and issues the first entry whose level
// matches. Optional feature macro QBANK_NOREPEAT_EN: skip the last issued
// entry unless it turns out to be the only match.
module q_bank
    import qbank_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int DIGITS  = 3,
    parameter int FACTORS = 3,
    parameter int LEVEL_W = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     OK,
    input  logic [LEVEL_W-1:0]       LEVEL,
    output logic [4*DIGITS-1:0]      QUESTION,
    output logic [4*FACTORS-1:0]     ANSWER,
    output logic [$clog2(DEPTH)-1:0] Q_INDEX,
    output logic                     VALID,
    output logic                     BUSY,
    output logic                     MISS
);

    localparam int QW = 4 * DIGITS;
    localparam int AW_ANS = 4 * FACTORS;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    // Constant table, built by repeating the default table
    logic [LEVEL_W-1:0] tbl_level   [DEPTH];
    logic [QW-1:0]      tbl_problem [DEPTH];
    logic [AW_ANS-1:0]  tbl_answer  [DEPTH];

    // NOTE: the table is pure constants, so there is no storage to reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tbl
        localparam qentry_t ENT = DEFAULT_TABLE[gi % DEF_DEPTH];
        assign tbl_level[gi]   = LEVEL_W'(ENT.level);
        assign tbl_problem[gi] = QW'(ENT.problem);
        assign tbl_answer[gi]  = AW_ANS'(ENT.answer);
    end

    logic [AW-1:0] lfsr_ptr;

    qbank_lfsr #(.OUT_W(AW)) u_lfsr (
        .clk_i (CLK),
        .rst_i (RST),
        .ptr_o (lfsr_ptr)
    );

    state_t             state_q, state_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [QW-1:0]      question_q, question_d;
    logic [AW_ANS-1:0]  answer_q, answer_d;
    logic [AW-1:0]      index_q, index_d;
    logic               valid_q, valid_d;
    logic               miss_q, miss_d;

    logic               hit;
    logic               load;
    logic [AW-1:0]      load_idx;

`ifdef QBANK_NOREPEAT_EN
    logic [AW-1:0]      last_q, last_d;
    logic               last_vld_q, last_vld_d;
    logic               skip_hit_q, skip_hit_d;
    logic               skip_now;
`endif

    // Next-state and output-register logic for the IDLE/SEARCH/DONE FSM
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        question_d = question_q;
        answer_d   = answer_q;
        index_d    = index_q;
        valid_d    = valid_q;
        miss_d     = miss_q;
        load       = 1'b0;
        load_idx   = ptr_q;
        hit        = (tbl_level[ptr_q] == level_q);
`ifdef QBANK_NOREPEAT_EN
        last_d     = last_q;
        last_vld_d = last_vld_q;
        skip_hit_d = skip_hit_q;
        skip_now   = last_vld_q && (ptr_q == last_q);
`endif

        case (state_q)
            IDLE, DONE: begin
                if (OK) begin
                    level_d = LEVEL;
                    ptr_d   = lfsr_ptr;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    miss_d  = 1'b0;
                    state_d = SEARCH;
`ifdef QBANK_NOREPEAT_EN
                    skip_hit_d = 1'b0;
`endif
                end
            end
            SEARCH: begin
`ifdef QBANK_NOREPEAT_EN
                if (hit && skip_now) begin
                    skip_hit_d = 1'b1;
                end
                if (hit && !skip_now) begin
                    load = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    if (skip_hit_q || (hit && skip_now)) begin
                        // The skipped entry was the only match: issue it anyway
                        load     = 1'b1;
                        load_idx = last_q;
                    end else begin
                        miss_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
`else
                if (hit) begin
                    load = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    miss_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            question_d = tbl_problem[load_idx];
            answer_d   = tbl_answer[load_idx];
            index_d    = load_idx;
            valid_d    = 1'b1;
            state_d    = DONE;
`ifdef QBANK_NOREPEAT_EN
            last_d     = load_idx;
            last_vld_d = 1'b1;
`endif
        end
    end

    // State and output registers; reset wins over any request
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            level_q    <= '0;
            question_q <= '0;
            answer_q   <= '0;
            index_q    <= '0;
            valid_q    <= 1'b0;
            miss_q     <= 1'b0;
`ifdef QBANK_NOREPEAT_EN
            last_q     <= '0;
            last_vld_q <= 1'b0;
            skip_hit_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            question_q <= question_d;
            answer_q   <= answer_d;
            index_q    <= index_d;
            valid_q    <= valid_d;
            miss_q     <= miss_d;
`ifdef QBANK_NOREPEAT_EN
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            skip_hit_q <= skip_hit_d;
`endif
        end
    end

    assign QUESTION = question_q;
    assign ANSWER   = answer_q;
    assign Q_INDEX  = index_q;
    assign VALID    = valid_q;
    assign MISS     = miss_q;
    assign BUSY     = (state_q == SEARCH);

endmodule

// File: tb/tb_q_bank.sv
// Scoreboard bench for q_bank: directed requests push hand-computed results,
// a monitor pops and compares whenever VALID or MISS rises.
module tb_q_bank;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        OK  = 1'b0;
    logic [1:0]  LEVEL = 2'd0;
    logic [11:0] QUESTION;
    logic [11:0] ANSWER;
    logic [3:0]  Q_INDEX;
    logic        VALID;
    logic        BUSY;
    logic        MISS;

    q_bank dut (
        .CLK      (CLK),
        .RST      (RST),
        .OK       (OK),
        .LEVEL    (LEVEL),
        .QUESTION (QUESTION),
        .ANSWER   (ANSWER),
        .Q_INDEX  (Q_INDEX),
        .VALID    (VALID),
        .BUSY     (BUSY),
        .MISS     (MISS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          miss;
        logic [11:0] q;
        logic [11:0] a;
        logic [3:0]  idx;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    logic [7:0] lfsr_m = 8'hA5;
    logic prev_valid = 1'b0;
    logic prev_miss  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference LFSR, used only to pick the cycle that yields a wanted start pointer
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RST) lfsr_m <= 8'hA5;
        else     lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 8'hB8) : (lfsr_m >> 1);
    end

    // Monitor: each rising VALID or MISS consumes one expected result
    always @(negedge CLK) begin
        if (!RST && ((VALID && !prev_valid) || (MISS && !prev_miss))) begin
            check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("miss_flag", 32'(MISS), 32'(mon_e.miss));
                check("valid",     32'(VALID), 32'(!mon_e.miss));
                check("question",  32'(QUESTION), 32'(mon_e.q));
                check("answer",    32'(ANSWER), 32'(mon_e.a));
                check("q_index",   32'(Q_INDEX), 32'(mon_e.idx));
                check("latency",   32'(cyc - accept_cyc), 32'(mon_e.lat));
                check("busy_end",  32'(BUSY), 32'd0);
            end
        end
        prev_valid = VALID;
        prev_miss  = MISS;
    end

    // One request: wait for the wanted start pointer, strobe OK, await the result
    task automatic run_vec(input logic [3:0] start, input logic [1:0] lvl, input bit miss,
                           input logic [11:0] q, input logic [11:0] a, input logic [3:0] idx,
                           input int lat, input bit pulse);
        exp_t e;
        int n = 0;
        while (lfsr_m[3:0] != start && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check("start_ptr_reached", 32'(n < 300), 32'd1);
        e.miss = miss; e.q = q; e.a = a; e.idx = idx; e.lat = lat;
        exp_q.push_back(e);
        OK = 1'b1;
        LEVEL = lvl;
        accept_cyc = cyc + 1;
        @(negedge CLK);
        OK = 1'b0;
        LEVEL = ~lvl;
        check("busy_after_ok", 32'(BUSY), 32'd1);
        if (pulse) begin
            @(negedge CLK);
            OK = 1'b1;
            LEVEL = 2'd0;
            @(negedge CLK);
            OK = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("result_in_time", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge CLK);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        // Reset state
        check("rst_question", 32'(QUESTION), 32'd0);
        check("rst_answer",   32'(ANSWER), 32'd0);
        check("rst_index",    32'(Q_INDEX), 32'd0);
        check("rst_valid",    32'(VALID), 32'd0);
        check("rst_busy",     32'(BUSY), 32'd0);
        check("rst_miss",     32'(MISS), 32'd0);
        check("rst_lfsr",     32'(dut.u_lfsr.lfsr_q), 32'hA5);
        RST = 1'b0;
        @(negedge CLK);

        // start, level, miss, question, answer, index, latency, ok-pulse
        run_vec(4'd2,  2'd1, 1'b0, 12'h042, 12'h124, 4'd2,  1,  1'b0);
        run_vec(4'd0,  2'd0, 1'b0, 12'h030, 12'h123, 4'd0,  1,  1'b0);
        run_vec(4'd2,  2'd0, 1'b0, 12'h030, 12'h123, 4'd3,  2,  1'b0);
        run_vec(4'd14, 2'd1, 1'b0, 12'h042, 12'h124, 4'd14, 1,  1'b0);
        run_vec(4'd15, 2'd1, 1'b0, 12'h042, 12'h124, 4'd2,  4,  1'b1);
        run_vec(4'd5,  2'd0, 1'b0, 12'h030, 12'h123, 4'd6,  2,  1'b0);
        run_vec(4'd1,  2'd0, 1'b0, 12'h027, 12'h222, 4'd1,  1,  1'b0);
        run_vec(4'd9,  2'd3, 1'b1, 12'h027, 12'h222, 4'd1,  16, 1'b0);
        run_vec(4'd7,  2'd0, 1'b0, 12'h027, 12'h222, 4'd7,  1,  1'b0);
`ifdef QBANK_NOREPEAT_EN
        run_vec(4'd7,  2'd0, 1'b0, 12'h030, 12'h123, 4'd9,  3,  1'b0);
`else
        run_vec(4'd7,  2'd0, 1'b0, 12'h027, 12'h222, 4'd7,  1,  1'b0);
`endif

        // Reset in the middle of a long search
        OK = 1'b1;
        LEVEL = 2'd3;
        @(negedge CLK);
        OK = 1'b0;
        repeat (4) @(negedge CLK);
        check("busy_before_rst", 32'(BUSY), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_busy",     32'(BUSY), 32'd0);
        check("midrst_valid",    32'(VALID), 32'd0);
        check("midrst_question", 32'(QUESTION), 32'd0);
        check("midrst_miss",     32'(MISS), 32'd0);
        check("midrst_lfsr",     32'(dut.u_lfsr.lfsr_q), 32'hA5);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        check("midrst_no_result", 32'(MISS | VALID), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
